// File: rtl/input_tile_memory.sv
// Dual-read, single-write store of 512-bit input tiles with
// a load counter, sticky out-of-range write flag and 1-cycle reads.
module input_tile_memory #(
  parameter int DEPTH = 128,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [511:0]  wr_data_i,
  input  logic          clear_i,
  input  logic [7:0]    expected_tiles_i,
  output logic [7:0]    tiles_loaded_o,
  output logic          load_done_o,
  output logic          wr_err_o,
  input  logic          input_request_i,
  input  logic [AW-1:0] input_addr_i_1,
  input  logic [AW-1:0] input_addr_i_2,
  output logic [511:0]  input_data_o_1,
  output logic [511:0]  input_data_o_2,
  output logic          input_valid_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [511:0] mem [DEPTH];

  logic wr_acc;
  logic wr_in;
  logic rd_in_1;
  logic rd_in_2;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Reads own the cycle; the loader is stalled whenever a request is up.
  assign wr_ready_o = !input_request_i && !reset;
  assign wr_acc     = wr_valid_i && wr_ready_o;
  assign wr_in      = wr_acc && in_range(wr_addr_i);
  assign rd_in_1    = input_request_i && in_range(input_addr_i_1);
  assign rd_in_2    = input_request_i && in_range(input_addr_i_2);

  assign load_done_o = (expected_tiles_i != 8'd0) &&
                       (tiles_loaded_o >= expected_tiles_i);

  always_ff @(posedge clk) begin
    if (wr_in) begin
      mem[wr_addr_i[IW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tiles_loaded_o <= 8'd0;
      wr_err_o       <= 1'b0;
    end else if (clear_i) begin
      tiles_loaded_o <= 8'd0;
      wr_err_o       <= 1'b0;
    end else if (wr_acc) begin
      if (tiles_loaded_o != 8'hFF) begin
        tiles_loaded_o <= tiles_loaded_o + 8'd1;
      end
      if (!wr_in) begin
        wr_err_o <= 1'b1;
      end
    end
  end

  // Out-of-range ports read as zero but still count as a served pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      input_valid_o  <= 1'b0;
      input_data_o_1 <= '0;
      input_data_o_2 <= '0;
    end else begin
      input_valid_o  <= input_request_i;
      input_data_o_1 <= rd_in_1 ? mem[input_addr_i_1[IW-1:0]] : '0;
      input_data_o_2 <= rd_in_2 ? mem[input_addr_i_2[IW-1:0]] : '0;
    end
  end

endmodule

// File: doc/input_tile_memory.md
INPUT_TILE_MEMORY -- requirements
Module: input_tile_memory

Interface
REQ-001 Parameter DEPTH, default 128; number of stored 512-bit input tiles.
REQ-002 Parameter AW, default 8; address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_valid_i  input  1  loader offers one tile write.
REQ-006 wr_ready_o  output  1  write accepted this cycle when high together with wr_valid_i.
REQ-007 wr_addr_i  input  AW  tile address of the write.
REQ-008 wr_data_i  input  512  signed tile, 36 entries x 12 bit, entry (i*6+j) at bits [(i*6+j)*12 +: 12], bits [511:432] zero.
REQ-009 clear_i  input  1  synchronous clear of the load counter and the error flag.
REQ-010 expected_tiles_i  input  8  tile count that completes a load.
REQ-011 tiles_loaded_o  output  8  count of accepted writes.
REQ-012 load_done_o  output  1  high while tiles_loaded_o >= expected_tiles_i and expected_tiles_i != 0.
REQ-013 wr_err_o  output  1  sticky flag for an accepted write with wr_addr_i >= DEPTH.
REQ-014 input_request_i  input  1  reader requests two tiles this cycle.
REQ-015 input_addr_i_1, input_addr_i_2  input  AW each  read addresses for ports 1 and 2.
REQ-016 input_data_o_1, input_data_o_2  output  512 each  returned tiles.
REQ-017 input_valid_o  output  1  input_data_o_1/2 are valid this cycle.

Function
REQ-018 Storage SHALL be DEPTH x 512 bits with one write port and two independent read ports; contents are not reset.
REQ-019 wr_ready_o SHALL equal !input_request_i && !reset; reads have priority and a write is never accepted in a request cycle.
REQ-020 An accepted write (wr_valid_i && wr_ready_o) with wr_addr_i < DEPTH SHALL store wr_data_i at the rising edge.
REQ-021 An accepted write with wr_addr_i >= DEPTH SHALL not modify storage and SHALL set wr_err_o on the next edge.
REQ-022 tiles_loaded_o SHALL increment by 1 on every accepted write, including out-of-range writes, and SHALL saturate at 255.
REQ-023 When clear_i is high, tiles_loaded_o and wr_err_o SHALL go to 0 on the next edge. This takes priority over a simultaneous increment or error set, and a write accepted in the same cycle still updates storage.
REQ-024 Read latency SHALL be exactly 1 cycle: a request at edge N produces input_valid_o=1 and data during cycle N+1.
REQ-025 Back-to-back requests SHALL be served at 1 pair/cycle with no bubbles.
REQ-026 A cycle with no request SHALL produce input_valid_o=0 and both data outputs all-zero in the following cycle.
REQ-027 A read address >= DEPTH on either port, including the 8'hFF "no second tile" marker, SHALL return all-zero data on that port, while input_valid_o stays 1.
REQ-028 input_addr_i_1 == input_addr_i_2 SHALL return identical data on both ports.
REQ-029 Storage for unwritten in-range addresses is don't-care; benches SHALL not check it.

Reset
REQ-030 Asserting reset SHALL immediately force input_valid_o=0, input_data_o_1/2=0, tiles_loaded_o=0, wr_err_o=0, load_done_o=0 and wr_ready_o=0.
REQ-031 A read in flight when reset asserts SHALL be discarded; no valid is produced after reset release without a new request.
REQ-032 A write presented during reset SHALL not be accepted.
REQ-033 Storage contents written before a mid-operation reset SHALL remain readable after release.

Verification
REQ-034 Write addr 0..3 with patterns P0..P3, expected_tiles_i=4 -> tiles_loaded_o=4, load_done_o=1; then request (0,1) -> next cycle valid=1, data P0/P1.
REQ-035 Consecutive requests (0,1),(2,3),(3,8'hFF) -> valid high 3 consecutive cycles with data P0/P1, P2/P3, P3/0; valid=0 the cycle after.
REQ-036 wr_valid_i held high while input_request_i=1 for 2 cycles -> wr_ready_o=0 for those cycles, tiles_loaded_o unchanged; the write lands on the first non-request cycle.
REQ-037 Write to addr 200 with DEPTH=128 -> wr_err_o=1, tiles_loaded_o incremented, storage unchanged; clear_i -> both 0 next cycle.
REQ-038 255 writes followed by 3 more -> tiles_loaded_o stays 255.
REQ-039 Reset pulse mid-read, between the request and the valid cycle -> outputs zero immediately, no valid after release; re-request (2,3) -> P2/P3.
